// File: rtl/seg7_readback_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_readback_monitor                                        |
// | Description : Samples a 7-segment bus, filters glitches, decodes it back   |
// |               to a countdown digit and flags illegal glyphs or sequences.  |
// |               Optional err_count output when SEG7_ERR_COUNTER_EN defined.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module seg7_readback_monitor #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned MAX_COUNT      = 9,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg7,
    input  logic       clear_err,
    output logic [3:0] digit_out,
    output logic       blank_out,
    output logic       digit_valid,
    output logic       pattern_err,
    output logic       seq_err
`ifdef SEG7_ERR_COUNTER_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);
    localparam logic [3:0] MAX_DIG  = 4'(MAX_COUNT);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    logic [6:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [7:0] stab_q, stab_d;
    logic [6:0] last_q, last_d;
    logic [3:0] prev_q, prev_d;
    state_t     state_q, state_d;
    logic [3:0] digit_q, digit_d;
    logic       blank_q, blank_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       serr_q, serr_d;
    logic [6:0] sample;
    logic [4:0] dec;
    logic       accept;
    logic       pat_evt;
    logic       seq_evt;

    // Returns {legal, value}; legal=0 covers both blank and junk codes.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   decode = 5'h10;
            7'h06:   decode = 5'h11;
            7'h5B:   decode = 5'h12;
            7'h4F:   decode = 5'h13;
            7'h66:   decode = 5'h14;
            7'h6D:   decode = 5'h15;
            7'h7D:   decode = 5'h16;
            7'h07:   decode = 5'h17;
            7'h7F:   decode = 5'h18;
            7'h6F:   decode = 5'h19;
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        sync1_d = seg7;
        sync2_d = sync1_q;
        last_d  = last_q;
        prev_d  = prev_q;
        state_d = state_q;
        digit_d = digit_q;
        blank_d = blank_q;
        valid_d = 1'b0;
        pat_evt = 1'b0;
        seq_evt = 1'b0;

        // sync1_q is the newest synchronized sample, sync2_q the one before it.
        if (sync1_q == sync2_q) begin
            stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 8'd1;
        end else begin
            stab_d = 8'd0;
        end

        sample = SEG_ACTIVE_LOW ? ~sync1_q : sync1_q;
        dec    = decode(sample);
        accept = (stab_d == STAB_MAX) && (stab_q != STAB_MAX) && (sample != last_q);

        if (accept) begin
            last_d  = sample;
            valid_d = 1'b1;
            if (sample == 7'h00) begin
                blank_d = 1'b1;
                state_d = ST_IDLE;
            end else if (dec[4]) begin
                digit_d = dec[3:0];
                blank_d = 1'b0;
                if (dec[3:0] > MAX_DIG) begin
                    seq_evt = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    if (state_q == ST_TRACK &&
                        !((prev_q != 4'd0 && dec[3:0] == prev_q - 4'd1) ||
                          (prev_q == 4'd0 && dec[3:0] == MAX_DIG))) begin
                        seq_evt = 1'b1;
                    end
                    state_d = ST_TRACK;
                    prev_d  = dec[3:0];
                end
            end else begin
                pat_evt = 1'b1;
                blank_d = 1'b0;
                state_d = ST_IDLE;
            end
        end

        // A new error event outranks a simultaneous clear.
        perr_d = (perr_q & ~clear_err) | pat_evt;
        serr_d = (serr_q & ~clear_err) | seq_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 7'h00;
            sync2_q <= 7'h00;
            stab_q  <= 8'd0;
            last_q  <= 7'h00;
            prev_q  <= 4'd0;
            state_q <= ST_IDLE;
            digit_q <= 4'd0;
            blank_q <= 1'b1;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            stab_q  <= stab_d;
            last_q  <= last_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            digit_q <= digit_d;
            blank_q <= blank_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
        end
    end

    assign digit_out   = digit_q;
    assign blank_out   = blank_q;
    assign digit_valid = valid_q;
    assign pattern_err = perr_q;
    assign seq_err     = serr_q;

`ifdef SEG7_ERR_COUNTER_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (clear_err) begin
            err_count_d = {7'd0, pat_evt | seq_evt};
        end else if ((pat_evt | seq_evt) && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg7_readback_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg7_readback_monitor                                     |
// | Description : Directed + randomized bench for seg7_readback_monitor with   |
// |               a history-based reference model.                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_seg7_readback_monitor;

    localparam int unsigned STABLE_CYCLES  = 4;
    localparam int unsigned MAX_COUNT      = 9;
    localparam bit          SEG_ACTIVE_LOW = 1'b0;
    localparam logic [6:0]  GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg7;
    logic       clear_err;
    logic [3:0] digit_out;
    logic       blank_out;
    logic       digit_valid;
    logic       pattern_err;
    logic       seq_err;
`ifdef SEG7_ERR_COUNTER_EN
    logic [7:0] err_count;
`endif

    seg7_readback_monitor #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_COUNT     (MAX_COUNT),
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg7       (seg7),
        .clear_err  (clear_err),
        .digit_out  (digit_out),
        .blank_out  (blank_out),
        .digit_valid(digit_valid),
        .pattern_err(pattern_err),
        .seq_err    (seq_err)
`ifdef SEG7_ERR_COUNTER_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: history of synchronized bus values, oldest first.
    logic [6:0] hist[$];
    logic [6:0] m_last;
    int         m_prev;
    logic [3:0] m_digit;
    logic       m_blank, m_valid, m_perr, m_serr;
    int         m_cnt;

    function automatic int glyph_value(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (GLYPH[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(7'h00);
        hist.push_back(7'h00);
        m_last = 7'h00; m_prev = -1; m_digit = 4'd0; m_blank = 1'b1;
        m_valid = 1'b0; m_perr = 1'b0; m_serr = 1'b0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic [6:0] s, input logic clr);
        int run = 0;
        int d;
        logic [6:0] p;
        bit pe = 0, se = 0;
        for (int i = hist.size() - 1; i > 0; i--) begin
            if (hist[i] == hist[i-1]) run++;
            else break;
        end
        p = hist[hist.size()-1] ^ (SEG_ACTIVE_LOW ? 7'h7F : 7'h00);
        m_valid = (run == int'(STABLE_CYCLES)) && (p != m_last);
        if (m_valid) begin
            m_last = p;
            d = glyph_value(p);
            if (p == 7'h00) begin
                m_blank = 1'b1; m_prev = -1;
            end else if (d >= 0) begin
                m_digit = 4'(d); m_blank = 1'b0;
                if (d > int'(MAX_COUNT)) begin
                    se = 1; m_prev = -1;
                end else begin
                    if (m_prev >= 0 && !(d == m_prev - 1 || (m_prev == 0 && d == int'(MAX_COUNT))))
                        se = 1;
                    m_prev = d;
                end
            end else begin
                pe = 1; m_blank = 1'b0; m_prev = -1;
            end
        end
        m_perr = (m_perr && !clr) || pe;
        m_serr = (m_serr && !clr) || se;
        if (clr) m_cnt = (pe || se) ? 1 : 0;
        else if ((pe || se) && m_cnt < 255) m_cnt++;
        hist.push_back(s);
        if (hist.size() > STABLE_CYCLES + 2) void'(hist.pop_front());
    endtask

    task automatic compare_all();
        check("digit_valid", digit_valid, m_valid);
        check("digit_out", digit_out, m_digit);
        check("blank_out", blank_out, m_blank);
        check("pattern_err", pattern_err, m_perr);
        check("seq_err", seq_err, m_serr);
`ifdef SEG7_ERR_COUNTER_EN
        check("err_count", err_count, m_cnt);
`endif
    endtask

    // Inputs change on the falling edge; outputs are compared on the next one.
    task automatic cycle(input logic [6:0] s, input logic clr);
        seg7 = s;
        clear_err = clr;
        @(posedge clk);
        model_edge(s, clr);
        @(negedge clk);
        compare_all();
    endtask

    // Holds a pattern and reports the first cycle (1-based) digit_valid was seen, 0 if none.
    task automatic hold(input logic [6:0] s, input int n, output int lat);
        lat = 0;
        for (int i = 1; i <= n; i++) begin
            cycle(s, 1'b0);
            if (lat == 0 && digit_valid === 1'b1) lat = i;
        end
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        clear_err = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("rst_digit_out", digit_out, 4'd0);
        check("rst_blank_out", blank_out, 1'b1);
        check("rst_digit_valid", digit_valid, 1'b0);
        check("rst_pattern_err", pattern_err, 1'b0);
        check("rst_seq_err", seq_err, 1'b0);
    endtask

    initial begin
        int lat;
        int n;
        logic [6:0] s;
        rst = 1'b1;
        seg7 = 7'h00;
        clear_err = 1'b0;
        @(negedge clk);
        apply_reset(3);

        hold(7'h00, 20, lat);
        check("idle_no_pulse", lat, 0);

        hold(7'h7F, 10, lat);  check("lat_8", lat, 6);
        hold(7'h6F, 10, lat);  check("lat_9", lat, 6);
        hold(7'h7F, 10, lat);  check("lat_8b", lat, 6);
        check("step_up_seq_err", seq_err, 1'b1);
        check("step_up_digit", digit_out, 4'd8);

        hold(7'h00, 8, lat);
        cycle(7'h00, 1'b1);
        foreach (GLYPH[i]) hold(GLYPH[9-i], 8, lat);
        hold(7'h6F, 8, lat);
        check("reload_digit", digit_out, 4'd9);
        check("reload_seq_err", seq_err, 1'b0);

        hold(7'h00, 8, lat);
        hold(7'h5B, 10, lat);  check("glitch_first", lat, 6);
        hold(7'h4F, 3, lat);   check("glitch_none", lat, 0);
        hold(7'h5B, 10, lat);  check("glitch_repeat", lat, 0);
        check("glitch_perr", pattern_err, 1'b0);
        check("glitch_serr", seq_err, 1'b0);

        hold(7'h49, 8, lat);
        check("illegal_perr", pattern_err, 1'b1);
        check("illegal_digit", digit_out, 4'd2);
        cycle(7'h49, 1'b1);
        check("clear_perr", pattern_err, 1'b0);

        hold(7'h6D, 2, lat);
        apply_reset(2);
        hold(7'h6D, 10, lat);
        check("post_reset_lat", lat, 6);
        check("post_reset_digit", digit_out, 4'd5);

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0:       s = 7'h00;
                1:       s = 7'($urandom);
                default: s = GLYPH[$urandom_range(0, 9)];
            endcase
            n = $urandom_range(1, 10);
            for (int j = 0; j < n; j++) cycle(s, ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
